golden_nonce_uart_tx: RTL and testbench
=======================================

// Module: golden_nonce_uart_tx
// PURPOSE
//  Return path from hasher to host: accepts golden-nonce strobes from the hashing control unit,
//  buffers them in a small FIFO, and serialises each as a 4-byte UART 8N1 frame to the host.
//  Replaces the debug VIO readout on boards with no JTAG host attached.
//  Sits beside the control unit in the top level, in the hash_clk domain.
// PARAMETERS
//  CLK_FREQ         100000000  hash_clk frequency in Hz
//  BAUD             115200     UART bit rate
//  FIFO_DEPTH_LOG2  2          log2 of nonce FIFO depth (default 4 entries)
// PORTS
//  hash_clk     in   1   sole clock; all logic on posedge
//  reset_n      in   1   asynchronous, active-low reset
//  nonce_valid  in   1   one-cycle strobe: nonce carries a golden nonce
//  nonce        in   32  golden nonce value, sampled when nonce_valid=1
//  uart_tx      out  1   serial line, idle high
//  busy         out  1   1 while a frame is in progress or FIFO is non-empty
//  overflow     out  1   sticky: a nonce was dropped because the FIFO was full
//  fifo_level   out  FIFO_DEPTH_LOG2+1  entries currently held
// BEHAVIOUR
//  Reset (async assert, sync release): uart_tx=1, busy=0, overflow=0, fifo_level=0, FSM=IDLE,
//   FIFO pointers cleared; a frame in progress is abandoned (line returns high immediately).
//  Bit timing: DIV = (CLK_FREQ + BAUD/2) / BAUD; every serial bit lasts exactly DIV cycles.
//   Baud counter counts 0..DIV-1, is cleared on entry to START, free of drift across a frame.
//  FIFO push: nonce_valid && level<DEPTH -> write, level+1 next cycle.
//   nonce_valid && level==DEPTH -> drop, overflow<=1; full is judged on the registered level,
//   so a push coinciding with a pop while full is still dropped.
//  FIFO pop: FSM in IDLE with level>0 pops head into 32-bit shift reg, goes to START.
//   Simultaneous push+pop when not full: level unchanged.
//  Latency: push into empty FIFO at cycle N -> start bit (uart_tx=0) begins at cycle N+2.
//  FSM: IDLE -> START (1 bit, tx=0) -> DATA (8 bits, LSB first) -> STOP (1 bit, tx=1)
//   -> if byte_idx<3: byte_idx+1, START; else IDLE. No gap between bytes.
//   Byte order: nonce[7:0] first, nonce[31:24] last. Frame = 40 bit-times.
//  busy = (FSM!=IDLE) || (level!=0). uart_tx registered (no glitches).
//  Wrap-around: FIFO pointers are FIFO_DEPTH_LOG2 bits and wrap naturally; level is +1 wide.
// CONFIGURATION
//  GOLDEN_NONCE_DEDUP_EN defined: a strobe whose nonce equals the last accepted nonce is
//   silently discarded (no push, no overflow); last-accepted register resets to 32'hFFFFFFFF,
//   so a first nonce of 32'hFFFFFFFF is discarded (acceptable, documented).
//  Not defined: every accepted strobe is pushed, duplicates included.
// STRUCTURE
//  Shared package/include (miner_defs): FSM state encodings (IDLE/START/DATA/STOP),
//   UART frame constants (DATA_BITS=8, BYTES_PER_NONCE=4), DIV computation macro.
//  One sub-module: nonce_fifo (sync FIFO, 32-bit wide, param depth, level/full/empty out).
//  Top holds baud counter, bit/byte counters, shift register, FSM, dedup logic.
// TESTING  (CLK_FREQ=1000000, BAUD=100000 -> DIV=10, 400 cycles per nonce)
//  1 Single nonce 32'hA1B2C3D4 at cycle 10 -> start bit at cycle 12; bytes D4,C3,B2,A1 LSB-first,
//    each bit 10 cycles; busy falls the cycle the last stop bit ends.
//  2 Six strobes, 1 cycle apart, values 1..6 (depth 4) -> 1..5 transmitted in order
//    (first popped before 6th push frees a slot? no: 1 popped at push+1, so 1..5 sent), 6 dropped,
//    overflow=1 and stays 1 until reset.
//  3 Push while full coincident with pop -> push dropped, level stays DEPTH-1 after pop, overflow=1.
//  4 Assert reset_n=0 mid-byte-2 -> uart_tx=1 asynchronously, level=0, busy=0; after release
//    new nonce 32'h00000000 transmits full frame correctly.
//  5 DEDUP_EN: strobes 32'h55 twice then 32'h66 -> two frames (55, 66); without macro -> three.
//  6 Continuous stream at one nonce per 400 cycles for 20 nonces -> no gaps beyond pop latency,
//    overflow=0, decoded values match.

Source files
------------

// File: rtl/golden_nonce_uart_tx_pkg.sv
// Shared definitions for the golden-nonce UART return path: FSM states, frame constants and
// the baud divisor helper.
package golden_nonce_uart_tx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

  localparam int unsigned DataBits      = 8;
  localparam int unsigned BytesPerNonce = 4;

  // Rounded-to-nearest clocks per serial bit.
  function automatic int unsigned baud_div(input int unsigned clk_freq, input int unsigned baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/golden_nonce_uart_tx_nonce_fifo.sv
// Synchronous FIFO holding pending golden nonces; head is visible combinationally on rdata_o.
module golden_nonce_uart_tx_nonce_fifo #(
  parameter int unsigned Width     = 32,
  parameter int unsigned DepthLog2 = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic [Width-1:0]     wdata_i,
  input  logic                 pop_i,
  output logic [Width-1:0]     rdata_o,
  output logic [DepthLog2:0]   level_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned Depth = 1 << DepthLog2;
  localparam int unsigned LvlW  = DepthLog2 + 1;

  logic [Width-1:0]     mem_q [Depth];
  logic [DepthLog2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DepthLog2:0]   level_q;

  assign full_o  = (level_q == LvlW'(Depth));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally at Depth; the caller guarantees no push when full, no pop when empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/golden_nonce_uart_tx.sv
// Golden-nonce return path: FIFO-buffers nonce strobes and sends each as four 8N1 bytes, LSB
// byte first. Define GOLDEN_NONCE_DEDUP_EN to drop strobes repeating the last accepted nonce.
module golden_nonce_uart_tx
  import golden_nonce_uart_tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ        = 100000000,
  parameter int unsigned BAUD            = 115200,
  parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
  input  logic                       hash_clk,
  input  logic                       reset_n,
  input  logic                       nonce_valid,
  input  logic [31:0]                nonce,
  output logic                       uart_tx,
  output logic                       busy,
  output logic                       overflow,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_level
);

  localparam int unsigned Div  = baud_div(CLK_FREQ, BAUD);
  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;

  // Async assert, synchronous release.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic        nonce_dup;
  logic        accept;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [31:0] fifo_head;

`ifdef GOLDEN_NONCE_DEDUP_EN
  logic [31:0] last_nonce_q;

  always_ff @(posedge hash_clk or negedge rst_n) begin
    if (!rst_n)         last_nonce_q <= 32'hFFFF_FFFF;
    else if (fifo_push) last_nonce_q <= nonce;
  end
  assign nonce_dup = (nonce == last_nonce_q);
`else
  assign nonce_dup = 1'b0;
`endif

  tx_state_e         state_q;
  logic              tx_q;
  logic [CntW-1:0]   baud_cnt_q;
  logic [2:0]        bit_idx_q;
  logic [1:0]        byte_idx_q;
  logic [31:0]       shreg_q;
  logic              overflow_q;
  logic              bit_end;

  assign accept    = nonce_valid && !nonce_dup;
  // Full is judged on the registered level, so a push racing a pop while full is dropped.
  assign fifo_push = accept && !fifo_full;
  assign fifo_pop  = (state_q == StIdle) && !fifo_empty;
  assign bit_end   = (baud_cnt_q == CntW'(Div - 1));

  golden_nonce_uart_tx_nonce_fifo #(
    .Width     (32),
    .DepthLog2 (FIFO_DEPTH_LOG2)
  ) u_nonce_fifo (
    .clk_i   (hash_clk),
    .rst_ni  (rst_n),
    .push_i  (fifo_push),
    .wdata_i (nonce),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge hash_clk or negedge rst_n) begin
    if (!rst_n) overflow_q <= 1'b0;
    else if (accept && fifo_full) overflow_q <= 1'b1;
  end

  always_ff @(posedge hash_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      tx_q       <= 1'b1;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shreg_q    <= '0;
    end else begin
      if (state_q != StIdle) begin
        baud_cnt_q <= bit_end ? '0 : baud_cnt_q + CntW'(1);
      end
      case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            state_q    <= StStart;
            tx_q       <= 1'b0;
            shreg_q    <= fifo_head;
            baud_cnt_q <= '0;
            byte_idx_q <= '0;
          end
        end
        StStart: begin
          if (bit_end) begin
            state_q   <= StData;
            tx_q      <= shreg_q[0];
            bit_idx_q <= '0;
          end
        end
        StData: begin
          if (bit_end) begin
            // After eight shifts the next byte sits in shreg_q[7:0].
            shreg_q <= shreg_q >> 1;
            if (bit_idx_q == 3'(DataBits - 1)) begin
              state_q <= StStop;
              tx_q    <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shreg_q[1];
            end
          end
        end
        StStop: begin
          if (bit_end) begin
            if (byte_idx_q == 2'(BytesPerNonce - 1)) begin
              state_q <= StIdle;
            end else begin
              byte_idx_q <= byte_idx_q + 2'd1;
              state_q    <= StStart;
              tx_q       <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign uart_tx  = tx_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_golden_nonce_uart_tx.sv
// Directed bench for golden_nonce_uart_tx at DIV=10 (1 MHz clock, 100 kbaud, depth 4).
module tb_golden_nonce_uart_tx;

  localparam int unsigned CLK_FREQ = 1000000;
  localparam int unsigned BAUD     = 100000;
  localparam int          DIV      = 10;
  localparam int          DEPTH    = 4;

  logic        hash_clk = 1'b0;
  logic        reset_n;
  logic        nonce_valid;
  logic [31:0] nonce;
  logic        uart_tx;
  logic        busy;
  logic        overflow;
  logic [2:0]  fifo_level;

  int total = 0;
  int bad   = 0;

  golden_nonce_uart_tx #(
    .CLK_FREQ        (CLK_FREQ),
    .BAUD            (BAUD),
    .FIFO_DEPTH_LOG2 (2)
  ) dut (
    .hash_clk    (hash_clk),
    .reset_n     (reset_n),
    .nonce_valid (nonce_valid),
    .nonce       (nonce),
    .uart_tx     (uart_tx),
    .busy        (busy),
    .overflow    (overflow),
    .fifo_level  (fifo_level)
  );

  always #5 hash_clk = ~hash_clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [31:0] nonce_in;
    logic [31:0] exp_val;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge hash_clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n     = 1'b0;
    nonce_valid = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (3) tick();
  endtask

  // Valid during cycle N; returns in cycle N+1.
  task automatic push(input logic [31:0] v);
    nonce_valid = 1'b1;
    nonce       = v;
    tick();
    nonce_valid = 1'b0;
  endtask

  task automatic wait_start(input int limit, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      if (uart_tx === 1'b0) seen = 1'b1;
      else tick();
    end
  endtask

  // cur0 = cycles already elapsed since the first cycle of the start bit; samples mid-bit.
  task automatic decode(input int cur0, output logic [31:0] val, output logic ok);
    int cur;
    int tgt;
    cur = cur0;
    val = '0;
    ok  = 1'b1;
    for (int b = 0; b < 4; b++) begin
      for (int j = 0; j < 10; j++) begin
        tgt = (b * 10 + j) * DIV + DIV / 2;
        while (cur < tgt) begin
          tick();
          cur++;
        end
        if (j == 0) begin
          if (uart_tx !== 1'b0) ok = 1'b0;
        end else if (j == 9) begin
          if (uart_tx !== 1'b1) ok = 1'b0;
        end else begin
          val[b * 8 + j - 1] = uart_tx;
        end
      end
    end
  endtask

  task automatic recv(output logic [31:0] val, output logic ok);
    logic seen;
    wait_start(1000, seen);
    if (seen) begin
      decode(0, val, ok);
    end else begin
      val = '0;
      ok  = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] val;
    logic        ok;
    logic        seen;
    logic        exp_bit;
    int          errs;
    int          n_exp5;
    logic [31:0] exp5 [3];

    vecs[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[1] = '{32'h0000_0000, 32'h0000_0000};
    vecs[2] = '{32'h8000_0001, 32'h8000_0001};
    vecs[3] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF};
    for (int i = 4; i < 20; i++) begin
      vecs[i].nonce_in = 32'h9E37_79BA * i;
      vecs[i].exp_val  = 32'h9E37_79BA * i;
    end

    reset_n     = 1'b0;
    nonce_valid = 1'b0;
    nonce       = '0;
    apply_reset();

    check("reset_uart_tx", 32'(uart_tx), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    check("reset_level", 32'(fifo_level), 32'd0);

    // 1: single nonce, exact bit-level waveform.
    push(32'hA1B2_C3D4);
    check("t1_level_after_push", 32'(fifo_level), 32'd1);
    check("t1_tx_idle_n1", 32'(uart_tx), 32'd1);
    check("t1_busy_n1", 32'(busy), 32'd1);
    tick();
    check("t1_start_at_n2", 32'(uart_tx), 32'd0);
    errs = 0;
    for (int t = 0; t < 400; t++) begin
      if ((t / 10) % 10 == 0)      exp_bit = 1'b0;
      else if ((t / 10) % 10 == 9) exp_bit = 1'b1;
      else begin
        val     = 32'hA1B2_C3D4;
        exp_bit = val[(t / 100) * 8 + (t / 10) % 10 - 1];
      end
      if (uart_tx !== exp_bit) errs++;
      if (t < 399) tick();
    end
    check("t1_waveform_mismatches", 32'(errs), 32'd0);
    check("t1_busy_last_cycle", 32'(busy), 32'd1);
    tick();
    check("t1_busy_fall", 32'(busy), 32'd0);
    check("t1_tx_idle_after", 32'(uart_tx), 32'd1);

    // 2: six back-to-back strobes into depth 4 -> 1..5 sent, 6 dropped.
    apply_reset();
    for (int i = 1; i <= 6; i++) push(32'(i));
    check("t2_level_full", 32'(fifo_level), 32'(DEPTH));
    check("t2_overflow_set", 32'(overflow), 32'd1);
    decode(4, val, ok);
    check("t2_frame1_val", val, 32'd1);
    check("t2_frame1_ok", 32'(ok), 32'd1);
    for (int i = 2; i <= 5; i++) begin
      recv(val, ok);
      check("t2_frame_val", val, 32'(i));
      check("t2_frame_ok", 32'(ok), 32'd1);
    end
    wait_start(600, seen);
    check("t2_no_sixth_frame", 32'(seen), 32'd0);
    check("t2_busy_done", 32'(busy), 32'd0);
    check("t2_overflow_sticky", 32'(overflow), 32'd1);

    // 3: push while full coinciding with pop is dropped.
    apply_reset();
    push(32'h1111_1111);
    push(32'h2222_2222);
    push(32'h3333_3333);
    push(32'h4444_4444);
    push(32'h5555_5555);
    check("t3_level_full", 32'(fifo_level), 32'(DEPTH));
    check("t3_no_overflow_yet", 32'(overflow), 32'd0);
    repeat (397) tick();
    check("t3_level_before_pop", 32'(fifo_level), 32'(DEPTH));
    check("t3_tx_idle_pop_cycle", 32'(uart_tx), 32'd1);
    push(32'h6666_6666);
    check("t3_level_after_pop", 32'(fifo_level), 32'(DEPTH - 1));
    check("t3_overflow", 32'(overflow), 32'd1);
    check("t3_next_start", 32'(uart_tx), 32'd0);
    decode(0, val, ok);
    check("t3_second_val", val, 32'h2222_2222);

    // 4: asynchronous reset mid byte 1, then a clean frame of zeros.
    apply_reset();
    push(32'h1234_5678);
    tick();
    check("t4_start", 32'(uart_tx), 32'd0);
    repeat (115) tick();
    check("t4_mid_byte_low", 32'(uart_tx), 32'd0);
    reset_n = 1'b0;
    #1;
    check("t4_async_tx_high", 32'(uart_tx), 32'd1);
    check("t4_async_level", 32'(fifo_level), 32'd0);
    check("t4_async_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (4) tick();
    check("t4_idle_after_release", 32'(uart_tx), 32'd1);
    push(32'h0000_0000);
    tick();
    check("t4_restart_latency", 32'(uart_tx), 32'd0);
    decode(0, val, ok);
    check("t4_zero_val", val, 32'h0000_0000);
    check("t4_zero_ok", 32'(ok), 32'd1);

    // 5: duplicate strobes.
    apply_reset();
`ifdef GOLDEN_NONCE_DEDUP_EN
    n_exp5  = 2;
    exp5[0] = 32'h55;
    exp5[1] = 32'h66;
    exp5[2] = 32'h0;
`else
    n_exp5  = 3;
    exp5[0] = 32'h55;
    exp5[1] = 32'h55;
    exp5[2] = 32'h66;
`endif
    push(32'h55);
    push(32'h55);
    push(32'h66);
    decode(1, val, ok);
    check("t5_frame0", val, exp5[0]);
    for (int i = 1; i < n_exp5; i++) begin
      recv(val, ok);
      check("t5_frame", val, exp5[i]);
      check("t5_frame_ok", 32'(ok), 32'd1);
    end
    wait_start(600, seen);
    check("t5_no_extra_frame", 32'(seen), 32'd0);
    check("t5_overflow", 32'(overflow), 32'd0);

    // 6: table-driven stream, one nonce per frame slot.
    for (int i = 0; i < 20; i++) begin
      push(vecs[i].nonce_in);
      tick();
      check("t6_start_latency", 32'(uart_tx), 32'd0);
      decode(0, val, ok);
      check("t6_val", val, vecs[i].exp_val);
      check("t6_ok", 32'(ok), 32'd1);
      repeat (4) tick();
      check("t6_busy_last", 32'(busy), 32'd1);
      tick();
      check("t6_busy_fall", 32'(busy), 32'd0);
    end
    check("t6_overflow", 32'(overflow), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
